isa_io_target: RTL and testbench
================================

ISA_IO_TARGET -- requirements
Module: isa_io_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0220, meaning the ISA I/O base of a 16-byte window (BASE_ADDR[3:0] ignored).
REQ-002 SHALL have ports, clock and reset first:
- clk_50MHz  input  1  sole clock
- global_reset  input  1  asynchronous, active-low reset
- A  input  16  ISA address bus
- D_in  input  8  ISA data bus, low byte, as sampled
- D_out  output  8  read data to ISA bus
- D_oe  output  1  high = drive D_out onto D[7:0]
- IOR  input  1  ISA I/O read strobe, active-low
- IOW  input  1  ISA I/O write strobe, active-low
- AEN  input  1  high = DMA cycle, decode inhibited
- IRQ  output  1  interrupt to host, active-high
- wr_valid  output  1  write-FIFO head valid
- wr_offset  output  4  head entry register offset
- wr_data  output  8  head entry data
- wr_ready  input  1  local consumer pops the head when high with wr_valid
- ld_en  input  1  load readback register
- ld_offset  input  4  readback register index, 0-14
- ld_data  input  8  readback load value
- irq_set  input  1  one-cycle pulse requesting IRQ
- ovf_clr  input  1  clears the overflow flag

Function
REQ-003 IOR and IOW SHALL each pass through a 2-flop synchronizer; A, D_in and AEN SHALL NOT be synchronized and SHALL be sampled only in the capture cycle.
REQ-004 hit SHALL be AEN==0 AND A[15:10]==0 AND A[9:4]==BASE_ADDR[9:4]; offset = A[3:0].
REQ-005 FSM states: IDLE, WR_CAP, RD_DRIVE, WAIT_REL.
REQ-006 IDLE: synced IOW low and IOR high -> WR_CAP; synced IOR low and IOW high -> RD_DRIVE when hit, WAIT_REL when not hit; both low -> WAIT_REL.
REQ-007 WR_CAP SHALL last one cycle, sampling A, D_in and AEN.
- If hit and FIFO not full (or pop in the same cycle), SHALL push {offset, D_in}.
- If hit and full with no pop, SHALL drop the write and set overflow.
- Then -> WAIT_REL.
REQ-008 On RD_DRIVE entry, SHALL latch D_out = readback[offset] for offset 0-14 and status for offset 15. SHALL hold D_oe=1 until synced IOR is seen high, then D_oe=0 and -> IDLE in that same cycle.
REQ-009 Status byte SHALL be {IRQ, overflow, fifo_count[2:0], 3'b000}.
REQ-010 WAIT_REL SHALL return to IDLE when both synced strobes are high; D_oe SHALL be 0 in WAIT_REL.
REQ-011 Write FIFO SHALL be 4 entries deep, first-in first-out, with fifo_count 0-4.
- wr_valid = (count != 0); wr_offset and wr_data show the head entry.
- Pop when wr_valid and wr_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-012 ld_en SHALL write ld_data into readback[ld_offset] on the next edge; ld_offset 15 SHALL be ignored; an ld_en during RD_DRIVE SHALL NOT alter the latched D_out.
REQ-013 IRQ SHALL set on irq_set and clear when a read of offset 15 completes (the RD_DRIVE to IDLE transition); set SHALL win if both occur in the same cycle.
REQ-014 overflow SHALL be sticky until ovf_clr; a new overflow event in the same cycle as ovf_clr SHALL win.
REQ-015 Latency:
- IOW pad fall to wr_valid high: at most 4 clk_50MHz edges (empty FIFO).
- IOR pad fall to D_oe high: at most 3 edges.
- IOR pad rise to D_oe low: at most 3 edges.
REQ-016 A strobe re-asserting while in WAIT_REL SHALL NOT start a new cycle until both strobes have been seen high.

Reset
REQ-017 While global_reset is low, SHALL force:
- state=IDLE, D_oe=0, D_out=8'h00, IRQ=0, overflow=0
- FIFO empty, wr_valid=0, wr_offset=0, wr_data=0
- readback[0..14]=8'h00, synchronizers=1 (strobes idle)
REQ-018 Reset asserted mid-cycle SHALL drop D_oe immediately (asynchronously) and discard FIFO contents; a strobe still low after reset release SHALL be handled per REQ-016-equivalent: ignored until seen high.

Verification
REQ-019 IOW low for 500 ns, A=16'h0223, D_in=8'h5A, AEN=0 -> within 4 edges: wr_valid=1, wr_offset=3, wr_data=8'h5A; wr_ready=1 -> wr_valid=0 next edge.
REQ-020 ld_en offset 2 data 8'hC3, then IOR at A=16'h0222 -> D_oe=1, D_out=8'hC3 until IOR rises, then D_oe=0 within 3 edges.
REQ-021 Five hit writes with wr_ready=0 -> count=4, overflow=1, 5th write dropped; status read returns 8'b01100000; ovf_clr -> overflow=0.
REQ-022 irq_set pulse -> IRQ=1; read of A=16'h022F returns bit7=1; IRQ=0 after IOR rises; irq_set in the clear cycle -> IRQ stays 1.
REQ-023 IOW at A=16'h0230 or with AEN=1 -> no FIFO push, D_oe=0; IOR and IOW low together -> no push, no drive.
REQ-024 global_reset low during RD_DRIVE -> D_oe=0 immediately; IOR held low through release -> no drive until IOR rises and re-falls.

Source files
------------

// File: rtl/isa_io_target.sv
// ISA bus I/O target: a 16-byte window with a 4-deep write FIFO toward local logic,
// a 15-entry readback register file, a status byte at offset 15 and a host IRQ.
module isa_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h0220
) (
    input  logic        clk_50MHz,
    input  logic        global_reset,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        IOR,
    input  logic        IOW,
    input  logic        AEN,
    output logic        IRQ,
    output logic        wr_valid,
    output logic [3:0]  wr_offset,
    output logic [7:0]  wr_data,
    input  logic        wr_ready,
    input  logic        ld_en,
    input  logic [3:0]  ld_offset,
    input  logic [7:0]  ld_data,
    input  logic        irq_set,
    input  logic        ovf_clr
);

    typedef enum logic [1:0] {IDLE, WR_CAP, RD_DRIVE, WAIT_REL} state_t;

    state_t      state;
    logic        ior_p0, ior_p1, iow_p0, iow_p1;
    logic [1:0]  settle;
    logic        armed;
    logic        hit;
    logic [3:0]  offset;
    logic [3:0]  rd_offset;
    logic [7:0]  readback [0:15];
    logic [11:0] fifo_mem [0:3];
    logic [1:0]  wptr, rptr;
    logic [2:0]  count;
    logic        overflow;
    logic        push, pop, ovf_evt, rd_done;
    logic [7:0]  status;

    // Decode is combinational on the raw bus; it is only consulted in capture cycles.
    assign offset   = A[3:0];
    assign hit      = !AEN && (A[15:10] == 6'd0) && (A[9:4] == BASE_ADDR[9:4]);
    assign pop      = (count != 3'd0) && wr_ready;
    assign push     = (state == WR_CAP) && hit && ((count != 3'd4) || pop);
    assign ovf_evt  = (state == WR_CAP) && hit && (count == 3'd4) && !pop;
    assign rd_done  = (state == RD_DRIVE) && ior_p1;
    assign status   = {IRQ, overflow, count, 3'b000};

    assign wr_valid  = (count != 3'd0);
    assign wr_offset = fifo_mem[rptr][11:8];
    assign wr_data   = fifo_mem[rptr][7:0];

    // Stage p0/p1: strobe synchronizers, idle-high out of reset
    always_ff @(posedge clk_50MHz or negedge global_reset) begin
        if (!global_reset) begin
            ior_p0 <= 1'b1;
            ior_p1 <= 1'b1;
            iow_p0 <= 1'b1;
            iow_p1 <= 1'b1;
        end else begin
            ior_p0 <= IOR;
            ior_p1 <= ior_p0;
            iow_p0 <= IOW;
            iow_p1 <= iow_p0;
        end
    end

    // The synchronizer holds its reset value for two edges, so a strobe held low
    // through reset is only trusted once real samples show both strobes high.
    always_ff @(posedge clk_50MHz or negedge global_reset) begin
        if (!global_reset) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            if (settle == 2'd2 && ior_p1 && iow_p1)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz or negedge global_reset) begin
        if (!global_reset) begin
            state     <= IDLE;
            D_oe      <= 1'b0;
            D_out     <= 8'h00;
            rd_offset <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        if (!iow_p1 && ior_p1) begin
                            state <= WR_CAP;
                        end else if (!ior_p1 && iow_p1) begin
                            if (hit) begin
                                state     <= RD_DRIVE;
                                D_oe      <= 1'b1;
                                D_out     <= (offset == 4'hF) ? status : readback[offset];
                                rd_offset <= offset;
                            end else begin
                                state <= WAIT_REL;
                            end
                        end else if (!ior_p1 && !iow_p1) begin
                            state <= WAIT_REL;
                        end
                    end
                end
                WR_CAP: state <= WAIT_REL;
                RD_DRIVE: begin
                    if (ior_p1) begin
                        D_oe  <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT_REL: begin
                    D_oe <= 1'b0;
                    if (ior_p1 && iow_p1)
                        state <= IDLE;
                end
                default: begin
                    D_oe  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge global_reset) begin
        if (!global_reset) begin
            for (int i = 0; i < 4; i++)
                fifo_mem[i] <= 12'h000;
            wptr  <= 2'd0;
            rptr  <= 2'd0;
            count <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= {offset, D_in};
                wptr           <= wptr + 2'd1;
            end
            if (pop)
                rptr <= rptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_50MHz or negedge global_reset) begin
        if (!global_reset) begin
            for (int i = 0; i < 16; i++)
                readback[i] <= 8'h00;
        end else if (ld_en && ld_offset != 4'hF) begin
            readback[ld_offset] <= ld_data;
        end
    end

    // Set requests take priority over clears for both sticky flags.
    always_ff @(posedge clk_50MHz or negedge global_reset) begin
        if (!global_reset) begin
            IRQ      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (irq_set)
                IRQ <= 1'b1;
            else if (rd_done && rd_offset == 4'hF)
                IRQ <= 1'b0;
            if (ovf_evt)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_isa_io_target.sv
// Directed bench for isa_io_target: ISA strobe transactions with hand-computed results.
module tb_isa_io_target;

    logic        clk;
    logic        global_reset;
    logic [15:0] A;
    logic [7:0]  D_in;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        IOR, IOW, AEN;
    logic        IRQ;
    logic        wr_valid;
    logic [3:0]  wr_offset;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        ld_en;
    logic [3:0]  ld_offset;
    logic [7:0]  ld_data;
    logic        irq_set;
    logic        ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    isa_io_target #(.BASE_ADDR(16'h0220)) dut (
        .clk_50MHz(clk), .global_reset(global_reset), .A(A), .D_in(D_in),
        .D_out(D_out), .D_oe(D_oe), .IOR(IOR), .IOW(IOW), .AEN(AEN), .IRQ(IRQ),
        .wr_valid(wr_valid), .wr_offset(wr_offset), .wr_data(wr_data),
        .wr_ready(wr_ready), .ld_en(ld_en), .ld_offset(ld_offset), .ld_data(ld_data),
        .irq_set(irq_set), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe_write(input logic [15:0] a, input logic [7:0] d, input logic aen);
        @(negedge clk);
        A = a; D_in = d; AEN = aen; IOW = 1'b0;
        repeat (25) @(negedge clk);
        IOW = 1'b1;
        repeat (5) @(negedge clk);
        AEN = 1'b0;
    endtask

    task automatic strobe_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        A = a; IOR = 1'b0;
        repeat (10) @(negedge clk);
        d  = D_out;
        oe = D_oe;
        IOR = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic load_rb(input logic [3:0] off, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_offset = off; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic pulse_pop();
        @(negedge clk);
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
    endtask

    logic [7:0] rd;
    logic       oe;

    initial begin
        global_reset = 1'b0;
        A = 16'h0000; D_in = 8'h00; IOR = 1'b1; IOW = 1'b1; AEN = 1'b0;
        wr_ready = 1'b0; ld_en = 1'b0; ld_offset = 4'd0; ld_data = 8'h00;
        irq_set = 1'b0; ovf_clr = 1'b0;

        #35;
        check_val("rst_doe", D_oe, 1'b0);
        check_val("rst_dout", D_out, 8'h00);
        check_val("rst_irq", IRQ, 1'b0);
        check_val("rst_wr_valid", wr_valid, 1'b0);
        check_val("rst_wr_head", {wr_offset, wr_data}, 12'h000);
        @(negedge clk);
        global_reset = 1'b1;
        repeat (10) @(negedge clk);

        // Single write: latency, head contents, pop
        A = 16'h0223; D_in = 8'h5A; AEN = 1'b0; IOW = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("wr_lat_valid", wr_valid, 1'b1);
        check_val("wr_lat_offset", wr_offset, 4'd3);
        check_val("wr_lat_data", wr_data, 8'h5A);
        repeat (20) @(negedge clk);
        IOW = 1'b1;
        repeat (5) @(negedge clk);
        wr_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("wr_pop", wr_valid, 1'b0);
        @(negedge clk);
        wr_ready = 1'b0;

        // Readback read: latency, data hold across a concurrent load, release latency
        load_rb(4'd2, 8'hC3);
        @(negedge clk);
        A = 16'h0222; IOR = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rd_lat_oe", D_oe, 1'b1);
        check_val("rd_lat_data", D_out, 8'hC3);
        load_rb(4'd2, 8'h00);
        repeat (3) @(negedge clk);
        check_val("rd_hold_data", D_out, 8'hC3);
        check_val("rd_hold_oe", D_oe, 1'b1);
        IOR = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rd_release_oe", D_oe, 1'b0);
        repeat (5) @(negedge clk);

        // Overflow: five writes with no consumer
        for (int i = 0; i < 5; i++)
            strobe_write(16'h0220 + 16'(i), 8'h10 + 8'(i), 1'b0);
        strobe_read(16'h022F, rd, oe);
        check_val("ovf_status", rd, 8'b0110_0000);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        strobe_read(16'h022F, rd, oe);
        check_val("ovf_cleared_status", rd, 8'b0010_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("fifo_order", {wr_offset, wr_data}, {4'(i), 8'h10 + 8'(i)});
            pulse_pop();
        end
        check_val("fifo_drained", wr_valid, 1'b0);

        // IRQ set, status bit7, clear on status read, set wins over clear
        @(negedge clk);
        irq_set = 1'b1;
        @(negedge clk);
        irq_set = 1'b0;
        check_val("irq_set", IRQ, 1'b1);
        load_rb(4'hF, 8'hFF);
        strobe_read(16'h022F, rd, oe);
        check_val("irq_status", rd, 8'h80);
        check_val("irq_cleared", IRQ, 1'b0);
        @(negedge clk);
        irq_set = 1'b1;
        @(negedge clk);
        irq_set = 1'b0;
        A = 16'h022F; IOR = 1'b0;
        repeat (10) @(negedge clk);
        check_val("irq_rd_oe", D_oe, 1'b1);
        IOR = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        irq_set = 1'b1;
        @(posedge clk);
        #1;
        check_val("irq_clr_cycle_oe", D_oe, 1'b0);
        check_val("irq_set_wins", IRQ, 1'b1);
        @(negedge clk);
        irq_set = 1'b0;
        strobe_read(16'h022F, rd, oe);
        check_val("irq_reclear", IRQ, 1'b0);

        // Decode misses and conflicting strobes
        strobe_write(16'h0230, 8'hAA, 1'b0);
        strobe_write(16'h0223, 8'hBB, 1'b1);
        check_val("miss_no_push", wr_valid, 1'b0);
        strobe_read(16'h0230, rd, oe);
        check_val("miss_no_drive", oe, 1'b0);
        @(negedge clk);
        A = 16'h0221; IOR = 1'b0; IOW = 1'b0;
        repeat (10) @(negedge clk);
        check_val("both_no_drive", D_oe, 1'b0);
        check_val("both_no_push", wr_valid, 1'b0);
        IOR = 1'b1; IOW = 1'b1;
        repeat (5) @(negedge clk);

        // Read strobe arriving as write strobe releases: no new cycle until both seen high
        A = 16'h0224; D_in = 8'h66; IOW = 1'b0;
        repeat (10) @(negedge clk);
        A = 16'h0222; IOW = 1'b1; IOR = 1'b0;
        repeat (10) @(negedge clk);
        check_val("waitrel_no_drive", D_oe, 1'b0);
        check_val("waitrel_push", {wr_valid, wr_offset, wr_data}, {1'b1, 4'd4, 8'h66});
        IOR = 1'b1;
        repeat (5) @(negedge clk);
        pulse_pop();

        // Reset in the middle of a read
        load_rb(4'd2, 8'h77);
        strobe_write(16'h0225, 8'h99, 1'b0);
        @(negedge clk);
        A = 16'h0222; IOR = 1'b0;
        repeat (10) @(negedge clk);
        check_val("prereset_oe", D_oe, 1'b1);
        check_val("prereset_data", D_out, 8'h77);
        #5;
        global_reset = 1'b0;
        #1;
        check_val("async_rst_oe", D_oe, 1'b0);
        check_val("async_rst_fifo", wr_valid, 1'b0);
        repeat (3) @(negedge clk);
        global_reset = 1'b1;
        repeat (10) @(negedge clk);
        check_val("post_rst_held_ior", D_oe, 1'b0);
        IOR = 1'b1;
        repeat (5) @(negedge clk);
        strobe_read(16'h0222, rd, oe);
        check_val("post_rst_read_oe", oe, 1'b1);
        check_val("post_rst_readback", rd, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
